// File: rtl/regfile_pkg.sv
// Shared register-file types: widths, address/data typedefs and the writeback request record.
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        reg_addr_t rd;
        xlen_t     val;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback source bus: NUM_SRC requesters, each a valid/ready handshake carrying {rd, val}.
interface regfile_wb_ctrl_if import regfile_pkg::*; #(
    parameter int NUM_SRC = 3
) ();
    logic    [NUM_SRC-1:0] src_valid;
    logic    [NUM_SRC-1:0] src_ready;
    wb_req_t [NUM_SRC-1:0] src_req;

    modport master (output src_valid, output src_req, input  src_ready);
    modport slave  (input  src_valid, input  src_req, output src_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr, first requester wins.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_ptr_nxt
);
    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt     = '0;
        o_ptr_nxt = i_ptr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int off = 0; off < N; off++) begin
            w_idx = (int'(i_ptr) + off) % N;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_ptr_nxt    = PW'((w_idx + 1) % N);
            end
        end
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port arbiter: round-robin among writeback sources, one registered write per cycle,
// plus a busy scoreboard of reserved destinations for issue-stage hazard stalls.
module regfile_wb_ctrl import regfile_pkg::*; #(
    parameter int NUM_SRC = 3
) (
    input  logic      i_clk,
    input  logic      i_rst,
    regfile_wb_ctrl_if.slave src,
    output logic      o_rd_write_control,
    output reg_addr_t o_rd,
    output xlen_t     o_rd_write_val,
    input  logic      i_alloc_valid,
    input  reg_addr_t i_alloc_rd,
    output logic      o_alloc_ready,
    input  reg_addr_t i_chk_rs1,
    input  reg_addr_t i_chk_rs2,
    output logic      o_rs1_busy,
    output logic      o_rs2_busy,
    input  logic      i_flush
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_nxt;
    logic [NUM_SRC-1:0]  w_gnt;
    logic [NUM_SRC-1:0]  w_ready;
    logic                w_xfer;
    wb_req_t             w_sel;
    logic                r_wr_en;
    reg_addr_t           r_rd;
    xlen_t               r_val;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_set;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .i_req     (src.src_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_ptr_nxt (w_ptr_nxt)
    );

    // Output stage never backpressures, so a grant is a transfer; suppressed while in reset.
    assign w_ready       = i_rst ? '0 : w_gnt;
    assign src.src_ready = w_ready;
    assign w_xfer        = |w_ready;

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_ready[k]) w_sel = src.src_req[k];
        end
    end

    assign o_alloc_ready = !r_busy[i_alloc_rd];
    assign w_set         = i_alloc_valid && o_alloc_ready && (i_alloc_rd != '0);
    assign o_rs1_busy    = r_busy[i_chk_rs1];
    assign o_rs2_busy    = r_busy[i_chk_rs2];

    // Priority: retiring write clears, a new reservation overrides it, flush overrides both.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr_en) w_busy_nxt[r_rd] = 1'b0;
        if (w_set)   w_busy_nxt[i_alloc_rd] = 1'b1;
        if (i_flush) w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_wr_en <= 1'b0;
            r_rd    <= '0;
            r_val   <= '0;
            r_busy  <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wr_en <= w_xfer && (w_sel.rd != '0);
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
                r_rd  <= w_sel.rd;
                r_val <= w_sel.val;
            end
        end
    end

    assign o_rd_write_control = r_wr_en;
    assign o_rd               = r_rd;
    assign o_rd_write_val     = r_val;
endmodule
